// File: rtl/channel_err_inj_if.sv
// Symbol channel bus between a clean encoder source and the error injector.
// master drives the clean symbols and control; slave is the injector.
interface channel_err_inj_if #(parameter int W = 2);
  logic          valid_i;
  logic [W-1:0]  sym_i;
  logic [1:0]    mode_i;
  logic [3:0]    burst_len_i;
  logic [W-1:0]  err_mask_i;
  logic          clear_i;
  logic          valid_o;
  logic [W-1:0]  sym_o;
  logic [W-1:0]  err_o;
  logic [15:0]   bad_bit_ct_o;
  logic [15:0]   sym_ct_o;

  modport master (
    output valid_i, sym_i, mode_i, burst_len_i, err_mask_i, clear_i,
    input  valid_o, sym_o, err_o, bad_bit_ct_o, sym_ct_o
  );
  modport slave (
    input  valid_i, sym_i, mode_i, burst_len_i, err_mask_i, clear_i,
    output valid_o, sym_o, err_o, bad_bit_ct_o, sym_ct_o
  );
endinterface

// File: rtl/channel_err_inj.sv
// Channel error injector: clean / random single / random burst / forced bit flips.
// Define CHAN_ERR_STATS_EN to build the flipped-bit and symbol statistics counters.
module channel_err_inj #(
  parameter int          W    = 2,
  parameter int          N    = 5,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic              clk,
  input logic              rst,
  channel_err_inj_if.slave bus
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_nx;
  logic [3:0]    rem, rem_nx;
  logic [15:0]   lfsr;
  logic          trig, corrupt;
  logic [W-1:0]  err;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= SEED_EFF;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign trig = bus.valid_i && (&lfsr[N-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_nx;
      rem   <= rem_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    corrupt  = 1'b0;
    case (bus.mode_i)
      2'd1: corrupt = trig;
      2'd2: begin
        if (state == IDLE) begin
          corrupt = trig;
          if (trig && bus.burst_len_i != 4'd0) begin
            state_nx = BURST;
            rem_nx   = bus.burst_len_i;
          end
        end else if (bus.valid_i) begin
          // triggers landing here are ignored: no extension, no restart
          corrupt = 1'b1;
          rem_nx  = rem - 4'd1;
          if (rem <= 4'd1) state_nx = IDLE;
        end
      end
      2'd3:    corrupt = bus.valid_i;
      default: corrupt = 1'b0;
    endcase
    if (bus.mode_i != 2'd2) begin
      state_nx = IDLE;
      rem_nx   = 4'd0;
    end
  end

  assign err = corrupt ? bus.err_mask_i : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_o <= 1'b0;
      bus.sym_o   <= '0;
      bus.err_o   <= '0;
    end else begin
      bus.valid_o <= bus.valid_i;
      bus.err_o   <= err;
      if (bus.valid_i) bus.sym_o <= bus.sym_i ^ err;
    end
  end

`ifdef CHAN_ERR_STATS_EN
  logic [3:0]  pop;
  logic [16:0] bad_sum, sym_sum;

  always_comb begin
    pop = 4'd0;
    for (int i = 0; i < W; i++) pop = pop + 4'(err[i]);
  end

  assign bad_sum = {1'b0, bus.bad_bit_ct_o} + {13'd0, pop};
  assign sym_sum = {1'b0, bus.sym_ct_o} + 17'd1;

  // Counters track the symbol being registered, so they line up with valid_o
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bad_bit_ct_o <= 16'd0;
      bus.sym_ct_o     <= 16'd0;
    end else if (bus.clear_i) begin
      bus.bad_bit_ct_o <= 16'd0;
      bus.sym_ct_o     <= 16'd0;
    end else if (bus.valid_i) begin
      bus.bad_bit_ct_o <= bad_sum[16] ? 16'hFFFF : bad_sum[15:0];
      bus.sym_ct_o     <= sym_sum[16] ? 16'hFFFF : sym_sum[15:0];
    end
  end
`else
  logic unused_clear;
  assign unused_clear     = bus.clear_i;
  assign bus.bad_bit_ct_o = 16'd0;
  assign bus.sym_ct_o     = 16'd0;
`endif

endmodule

// File: tb/tb_channel_err_inj.sv
// Scoreboard bench for channel_err_inj: driver pushes expected symbols,
// negedge monitor pops and compares on every valid_o.
module tb_channel_err_inj;
  localparam int          W    = 2;
  localparam int          N    = 5;
  localparam logic [15:0] SEED = 16'hACFF;

  typedef struct packed {
    logic [W-1:0] sym;
    logic [W-1:0] err;
  } exp_t;

  logic clk, rst;
  channel_err_inj_if #(.W(W)) bus();

  channel_err_inj #(.W(W), .N(N), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  exp_t q[$];
  exp_t e_m;

  // reference model state
  logic [15:0]  m_lfsr;
  logic         m_burst;
  logic [3:0]   m_rem;
  logic [W-1:0] m_last;
  logic [15:0]  m_bad, m_sym;
  int           m_corr;
  int           corr_ct;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int popc(input logic [W-1:0] v);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(v[i]);
    return c;
  endfunction

  // Offset to the next LFSR state that triggers, with no trigger 4 steps later;
  // with inner=1 a second trigger must also fall inside the following 3 steps.
  function automatic int find_trig(input logic [15:0] s0, input bit inner);
    logic [15:0] s;
    logic [15:0] w [0:4];
    s = s0;
    for (int k = 0; k < 30000; k++) begin
      w[0] = s;
      for (int j = 1; j < 5; j++) w[j] = lstep(w[j-1]);
      if ((&w[0][N-1:0]) && !(&w[4][N-1:0]) &&
          (!inner || (&w[1][N-1:0]) || (&w[2][N-1:0]) || (&w[3][N-1:0])))
        return k;
      s = lstep(s);
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_lfsr = SEED; m_burst = 1'b0; m_rem = 4'd0; m_last = '0;
    m_bad = 16'd0; m_sym = 16'd0;
  endtask

  // Drive one cycle at negedge+1, update the model, return at the next negedge+1
  task automatic cycle(input logic v, input logic [W-1:0] s, input logic [1:0] m,
                       input logic [3:0] bl, input logic [W-1:0] mk, input logic clr);
    logic trig, corrupt;
    logic [W-1:0] e;
    bus.valid_i = v; bus.sym_i = s; bus.mode_i = m;
    bus.burst_len_i = bl; bus.err_mask_i = mk; bus.clear_i = clr;
    trig = v && (&m_lfsr[N-1:0]);
    corrupt = 1'b0;
    case (m)
      2'd1: corrupt = trig;
      2'd2: begin
        if (!m_burst) begin
          corrupt = trig;
          if (trig && bl != 4'd0) begin m_burst = 1'b1; m_rem = bl; end
        end else if (v) begin
          corrupt = 1'b1;
          m_rem = m_rem - 4'd1;
          if (m_rem == 4'd0) m_burst = 1'b0;
        end
      end
      2'd3: corrupt = v;
      default: corrupt = 1'b0;
    endcase
    if (m != 2'd2) begin m_burst = 1'b0; m_rem = 4'd0; end
    e = corrupt ? mk : '0;
    if (v) begin
      q.push_back('{sym: s ^ e, err: e});
      if (e != '0) m_corr++;
    end
`ifdef CHAN_ERR_STATS_EN
    if (clr) begin
      m_bad = 16'd0; m_sym = 16'd0;
    end else if (v) begin
      m_bad = (32'(m_bad) + popc(e) > 32'hFFFF) ? 16'hFFFF : m_bad + 16'(popc(e));
      m_sym = (m_sym == 16'hFFFF) ? 16'hFFFF : m_sym + 16'd1;
    end
`endif
    m_lfsr = lstep(m_lfsr);
    @(negedge clk); #1;
  endtask

  task automatic idle(input int k, input logic [1:0] m);
    for (int i = 0; i < k; i++) cycle(1'b0, '0, m, 4'd0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_o", 32'(bus.valid_o), 32'd0);
        end else begin
          e_m = q.pop_front();
          chk("sym_err", {bus.sym_o, bus.err_o}, {e_m.sym, e_m.err});
          m_last = e_m.sym;
          if (bus.err_o != '0) corr_ct++;
        end
      end else begin
        chk("idle_hold", {bus.sym_o, bus.err_o}, {m_last, {W{1'b0}}});
      end
      chk("counters", {bus.bad_bit_ct_o, bus.sym_ct_o}, {m_bad, m_sym});
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c0, t0;
    corr_ct = 0; m_corr = 0;
    rst = 1'b1;
    bus.valid_i = 0; bus.sym_i = '0; bus.mode_i = 2'd0;
    bus.burst_len_i = 4'd0; bus.err_mask_i = '0; bus.clear_i = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_valid_o", 32'(bus.valid_o), 0);
    chk("rst_sym_o", 32'(bus.sym_o), 0);
    chk("rst_err_o", 32'(bus.err_o), 0);
    chk("rst_bad_ct", 32'(bus.bad_bit_ct_o), 0);
    chk("rst_sym_ct", 32'(bus.sym_ct_o), 0);
    #1 rst = 1'b0;

    // forced mode: 10 x (10 ^ 01) = 11
    c0 = corr_ct;
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'b10, 2'd3, 4'd0, 2'b01, 1'b0);
    chk("mode3_corrupted", 32'(corr_ct - c0), 32'd10);
`ifdef CHAN_ERR_STATS_EN
    chk("mode3_bad_ct", 32'(bus.bad_bit_ct_o), 32'd10);
    chk("mode3_sym_ct", 32'(bus.sym_ct_o), 32'd10);
`else
    chk("mode3_bad_ct_off", 32'(bus.bad_bit_ct_o), 32'd0);
`endif

    // forced mode with zero mask flips nothing
    c0 = corr_ct;
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 2'd3, 4'd0, 2'b00, 1'b0);
    chk("mask0_corrupted", 32'(corr_ct - c0), 32'd0);

    // burst of 1+3 with a second trigger inside the burst
    cycle(1'b0, '0, 2'd2, 4'd0, '0, 1'b1);
    p = find_trig(m_lfsr, 1'b1);
    if (p < 0) chk("burst_search", 32'hFFFF_FFFF, 32'd0);
    else begin
      idle(p, 2'd2);
      c0 = corr_ct;
      for (int i = 0; i < 5; i++) cycle(1'b1, 2'b01, 2'd2, 4'd3, 2'b11, 1'b0);
      chk("burst_corrupted", 32'(corr_ct - c0), 32'd4);
`ifdef CHAN_ERR_STATS_EN
      chk("burst_bad_ct", 32'(bus.bad_bit_ct_o), 32'd8);
      chk("burst_sym_ct", 32'(bus.sym_ct_o), 32'd5);
`endif
    end

    // burst with a 2-cycle valid gap
    p = find_trig(m_lfsr, 1'b0);
    if (p < 0) chk("gap_search", 32'hFFFF_FFFF, 32'd0);
    else begin
      idle(p, 2'd2);
      c0 = corr_ct;
      cycle(1'b1, 2'b00, 2'd2, 4'd3, 2'b10, 1'b0);
      cycle(1'b1, 2'b01, 2'd2, 4'd3, 2'b10, 1'b0);
      cycle(1'b0, 2'b11, 2'd2, 4'd3, 2'b10, 1'b0);
      cycle(1'b0, 2'b11, 2'd2, 4'd3, 2'b10, 1'b0);
      cycle(1'b1, 2'b10, 2'd2, 4'd3, 2'b10, 1'b0);
      cycle(1'b1, 2'b11, 2'd2, 4'd3, 2'b10, 1'b0);
      idle(1, 2'd2);
      chk("gap_corrupted", 32'(corr_ct - c0), 32'd4);
    end

    // burst aborted by mode 0
    p = find_trig(m_lfsr, 1'b0);
    if (p >= 0) begin
      idle(p, 2'd2);
      cycle(1'b1, 2'b00, 2'd2, 4'd8, 2'b01, 1'b0);
      cycle(1'b1, 2'b00, 2'd2, 4'd8, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 2'd0, 4'd8, 2'b01, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'b11, 2'd2, 4'd8, 2'b01, 1'b0);
    end

    // random single errors over 4096 symbols
    cycle(1'b0, '0, 2'd1, 4'd0, '0, 1'b1);
    c0 = corr_ct; t0 = m_corr;
    for (int i = 0; i < 4096; i++) cycle(1'b1, 2'(i), 2'd1, 4'd0, 2'b11, 1'b0);
    chk("rand_vs_model", 32'(corr_ct - c0), 32'(m_corr - t0));
    chk("rand_in_range", 32'((corr_ct - c0) >= 88 && (corr_ct - c0) <= 168), 32'd1);
`ifdef CHAN_ERR_STATS_EN
    chk("rand_bad_ct", 32'(bus.bad_bit_ct_o), 32'(2 * (corr_ct - c0)));
    chk("rand_sym_ct", 32'(bus.sym_ct_o), 32'd4096);
`endif

    // reset mid-burst, then clean traffic
    p = find_trig(m_lfsr, 1'b0);
    if (p >= 0) begin
      idle(p, 2'd2);
      cycle(1'b1, 2'b01, 2'd2, 4'd9, 2'b11, 1'b0);
      cycle(1'b1, 2'b01, 2'd2, 4'd9, 2'b11, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_outputs", {bus.valid_o, bus.sym_o, bus.err_o, bus.bad_bit_ct_o, bus.sym_ct_o}, 0);
      q.delete();
      model_reset();
      bus.valid_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_hold", {bus.valid_o, bus.sym_o, bus.err_o, bus.bad_bit_ct_o, bus.sym_ct_o}, 0);
      #1 rst = 1'b0;
      c0 = corr_ct;
      for (int i = 0; i < 6; i++) cycle(1'b1, 2'b01, 2'd0, 4'd9, 2'b11, 1'b0);
      chk("postrst_clean", 32'(corr_ct - c0), 32'd0);
    end

`ifdef CHAN_ERR_STATS_EN
    for (int i = 0; i < 65540; i++) cycle(1'b1, 2'b10, 2'd0, 4'd0, '0, 1'b0);
    chk("sym_ct_sat", 32'(bus.sym_ct_o), 32'h0000FFFF);
    cycle(1'b1, 2'b10, 2'd0, 4'd0, '0, 1'b1);
    chk("clear_prio", 32'(bus.sym_ct_o), 32'd0);
`endif

    idle(2, 2'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/channel_err_inj.md
CHANNEL_ERR_INJ -- requirements
Module: channel_err_inj

Interface
REQ-001 SHALL have parameter W, default 2: channel symbol width in bits, range 1..8.
REQ-002 SHALL have parameter N, default 5: random-trigger rate exponent (probability 2^-N per valid symbol), range 1..16.
REQ-003 SHALL have parameter SEED, default 16'hACE1: LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port valid_i  input  1  sym_i qualifier.
REQ-007 SHALL have port sym_i  input  W  clean encoder symbol.
REQ-008 SHALL have port mode_i  input  2  0=clean, 1=random single, 2=random burst, 3=forced.
REQ-009 SHALL have port burst_len_i  input  4  extra corrupted symbols after a burst trigger.
REQ-010 SHALL have port err_mask_i  input  W  bit-flip pattern XORed onto a corrupted symbol.
REQ-011 SHALL have port clear_i  input  1  synchronous clear of the statistics counters.
REQ-012 SHALL have port valid_o  output  1  sym_o qualifier.
REQ-013 SHALL have port sym_o  output  W  possibly corrupted symbol.
REQ-014 SHALL have port err_o  output  W  flip mask actually applied to sym_o.
REQ-015 SHALL have port bad_bit_ct_o  output  16  count of flipped bits.
REQ-016 SHALL have port sym_ct_o  output  16  count of symbols output.

Function
REQ-017 SHALL register its outputs with a fixed latency of 1: valid_o(t+1)=valid_i(t), sym_o(t+1)=sym_i(t)^err_o(t+1).
REQ-018 SHALL hold a 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle, independent of valid_i.
REQ-019 SHALL raise a trigger when valid_i=1 and LFSR[N-1:0] are all ones.
REQ-020 SHALL apply mode 0: err_o=0 on every symbol, and SHALL abort any burst in progress in the same cycle.
REQ-021 SHALL apply mode 1: on a trigger, corrupt that symbol only (err_o=err_mask_i).
REQ-022 SHALL use a two-state FSM for mode 2, IDLE and BURST. In IDLE, a trigger corrupts the current symbol; if burst_len_i>0, the FSM loads remaining=burst_len_i and enters BURST.
REQ-023 In BURST, each valid_i symbol SHALL be corrupted and remaining decremented; when remaining reaches 0 the FSM returns to IDLE; cycles with valid_i=0 SHALL NOT decrement remaining.
REQ-024 A trigger occurring in BURST SHALL be ignored: the burst is neither extended nor restarted.
REQ-025 A change of mode_i away from 2 while in BURST SHALL force IDLE on the next edge.
REQ-026 SHALL apply mode 3: every valid symbol is corrupted with err_mask_i, with no LFSR dependence.
REQ-027 When valid_i=0, err_o SHALL be 0 and sym_o SHALL hold its previous value.
REQ-028 Corruption SHALL use err_mask_i as sampled in the cycle of the corrupted symbol; err_mask_i=0 SHALL yield no flips while the FSM still sequences.
REQ-029 On each valid_o, bad_bit_ct_o SHALL add popcount(err_o) and sym_ct_o SHALL add 1; both saturate at 16'hFFFF.
REQ-030 clear_i SHALL zero both counters on the next edge and take priority over any increment in that cycle.

Reset
REQ-031 When rst=1, outputs SHALL asynchronously reset to valid_o=0, sym_o=0, err_o=0, bad_bit_ct_o=0, sym_ct_o=0.
REQ-032 When rst=1, the FSM SHALL reset to IDLE, remaining to 0, and the LFSR to SEED.
REQ-033 Reset asserted mid-burst SHALL discard the burst; the first symbol after reset release SHALL be clean unless a new trigger or mode 3 applies.

Configuration
REQ-034 With macro CHAN_ERR_STATS_EN defined, the counters of REQ-029/030 SHALL be implemented.
REQ-035 Without CHAN_ERR_STATS_EN, bad_bit_ct_o and sym_ct_o SHALL be constant 0, clear_i SHALL be ignored, and no counter flops SHALL be inferred.

Verification
REQ-036 Mode 3, W=2, err_mask_i=2'b01, sym_i=2'b10 valid for 10 cycles -> sym_o=2'b11 for 10 cycles at 1-cycle latency; bad_bit_ct_o=10 and sym_ct_o=10.
REQ-037 Mode 2, burst_len_i=3, forced trigger (SEED chosen so LFSR[4:0]=5'h1F on the first valid) -> exactly 4 consecutive valid symbols corrupted; a second trigger inside the burst causes no extension.
REQ-038 Mode 2 burst in progress with valid_i deasserted 2 cycles mid-burst -> still 4 corrupted valid symbols in total, with err_o=0 during the gap.
REQ-039 Mode 1, N=5, 4096 valid symbols -> trigger count within 128±40, every corrupted symbol isolated, and bad_bit_ct_o=popcount(err_mask_i)×triggers.
REQ-040 rst pulsed mid-burst, then mode 0 -> all outputs 0 during reset and no corruption afterwards; separately, sym_ct_o preset to 16'hFFFF holds at 16'hFFFF, and clear_i together with valid_i -> 0.
